// File: rtl/writeback_regfile.sv
// writeback_regfile: write-back stage, 32x32 register file with two read ports, commit counter and serial register dump.
// Optional same-cycle write-to-read bypass is enabled by defining WB_BYPASS_EN.
module writeback_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MW_ALUout,
  input  logic [4:0]  MW_RD,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_count,
  input  logic        dump_req,
  output logic        dump_busy,
  output logic        dump_valid,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        dump_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_rf [32];
  logic [31:0] r_wb_count;
  logic [4:0]  r_idx;
  logic        r_dump_valid;
  logic [4:0]  r_dump_idx;
  logic [31:0] r_dump_data;
  logic        r_dump_done;
  logic        w_we;
  assign w_we = MW_RD != 5'd0;
`ifdef WB_BYPASS_EN
  assign rs_data = (rs_addr == 5'd0) ? 32'd0 : (w_we && rs_addr == MW_RD) ? MW_ALUout : r_rf[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 : (w_we && rt_addr == MW_RD) ? MW_ALUout : r_rf[rt_addr];
`else
  assign rs_data = (rs_addr == 5'd0) ? 32'd0 : r_rf[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 : r_rf[rt_addr];
`endif
  assign wb_count   = r_wb_count;
  assign dump_busy  = (r_state != IDLE) || r_dump_done;
  assign dump_valid = r_dump_valid;
  assign dump_idx   = r_dump_idx;
  assign dump_data  = r_dump_data;
  assign dump_done  = r_dump_done;
  // Commit the memory-stage result; register 0 is hardwired to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (w_we) begin
      r_rf[MW_RD] <= MW_ALUout;
    end
  end
  // Count committed writes, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wb_count <= 32'd0;
    else if (w_we) r_wb_count <= r_wb_count + 32'd1;
  end
  // Dump engine state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next_state;
  end
  // Dump next state: start from IDLE on request, walk 32 registers, one DONE cycle.
  always_comb begin
    w_next_state = IDLE;
    w_next_state = (r_state == IDLE) ? (dump_req ? RUN : IDLE) :
                   (r_state == RUN)  ? ((r_idx == 5'd31) ? DONE : RUN) : IDLE;
  end
  // Dump datapath: emit one register per RUN cycle from the pre-edge file contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx        <= 5'd0;
      r_dump_valid <= 1'b0;
      r_dump_idx   <= 5'd0;
      r_dump_data  <= 32'd0;
      r_dump_done  <= 1'b0;
    end else begin
      r_idx        <= (r_state == RUN) ? r_idx + 5'd1 : 5'd0;
      r_dump_valid <= r_state == RUN;
      r_dump_done  <= r_state == DONE;
      if (r_state == RUN) begin
        r_dump_idx  <= r_idx;
        r_dump_data <= r_rf[r_idx];
      end
    end
  end
endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage and architectural register file of the GCD CPU pipeline. Consumes the memory stage's registered result pair (`MW_ALUout`, `MW_RD`), commits it to a 32×32 register file, serves two combinational read ports to decode, and counts committed writes. A register-dump engine streams all 32 registers out serially for bench checking and end-of-program GCD result extraction.

## Interface
Parameters: none; widths fixed at 32 data, 5 address.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `MW_ALUout` in 32: result from memory stage (ALU, slt, or loaded word).
- `MW_RD` in 5: destination register; 0 means no write.
- `rs_addr` in 5: read port A address.
- `rt_addr` in 5: read port B address.
- `rs_data` out 32: read port A data, combinational.
- `rt_data` out 32: read port B data, combinational.
- `wb_count` out 32: number of committed writes, wraps.
- `dump_req` in 1: start a register dump (level, sampled in IDLE only).
- `dump_busy` out 1: dump engine not IDLE.
- `dump_valid` out 1: `dump_idx`/`dump_data` valid this cycle.
- `dump_idx` out 5: register index being dumped.
- `dump_data` out 32: register contents being dumped.
- `dump_done` out 1: one-cycle pulse after the last dump beat.

## Operation
- Write: each rising edge with `rst`=1 and `MW_RD`≠0: `RF[MW_RD] <= MW_ALUout`, `wb_count <= wb_count+1` (mod 2^32). `MW_RD`=0: no write, no count.
- `RF[0]` never written; reads of address 0 return 0.
- Read port X (A or B): addr 0 → 0; else if bypass hit (see Configuration) → `MW_ALUout`; else `RF[addr]`.
- Dump FSM states IDLE, RUN, DONE; index counter `idx` (5 bits).
  - IDLE: `dump_req`=1 → RUN, `idx<=0`.
  - RUN, every edge: `dump_valid<=1`, `dump_idx<=idx`, `dump_data<=RF[idx]` (pre-edge value; a same-edge write to `idx` is not reflected); `idx==31` → DONE, else `idx<=idx+1`.
  - DONE: `dump_valid<=0`, `dump_done<=1` for one cycle, → IDLE.
  - `dump_req` ignored outside IDLE; held high, a new dump starts on the edge after returning to IDLE.
- Writes proceed normally during a dump; dump never stalls write-back.

## Timing
- Reset (`rst`=0, async): all 32 registers 0, `wb_count`=0, FSM IDLE, `idx`=0, `dump_valid`=0, `dump_idx`=0, `dump_data`=0, `dump_done`=0, `dump_busy`=0. `rs_data`/`rt_data` then reflect zeroed RF.
- Write latency: value written at edge E is readable from `RF` after E (same cycle as E+ via bypass if enabled).
- Dump: `dump_req` sampled at E0 → `dump_busy`=1 after E0; `dump_valid`=1 from after E1 through after E32 (32 beats, idx 0..31 in order); `dump_done`=1 after E33 only; `dump_busy`=0 after E34 (IDLE). Busy covers RUN and DONE.
- Reset mid-dump: abort immediately, all dump outputs 0, IDLE; no `dump_done`.

## Configuration
- `WB_BYPASS_EN` defined: read port returns `MW_ALUout` when its addr equals `MW_RD` and `MW_RD`≠0 (write-first, same cycle).
- Undefined: read ports return `RF[addr]` only (old value until the edge); decode must avoid the hazard. Write, count, and dump behaviour identical in both builds.

## Test plan
- Reset: drive `rst`=0 mid-run after writes → all `rs_data`/`rt_data` 0, `wb_count`=0, dump outputs 0.
- Write/read: `MW_RD`=5, `MW_ALUout`=0x0000_0018 one cycle, then `MW_RD`=0 → `rs_addr`=5 reads 0x18, `wb_count`=1; `MW_RD`=0 with 0xFFFF_FFFF → `rs_addr`=0 reads 0, count unchanged.
- Bypass: `MW_RD`=7, `MW_ALUout`=0x2A, `rt_addr`=7 same cycle, RF[7]=0x11 → `WB_BYPASS_EN`: 0x2A; without: 0x11, then 0x2A after edge.
- Dump: preload RF[k]=k*3 → exactly 32 beats, `dump_idx`=0..31, `dump_data`=0,3,…,93, `dump_done` one cycle after beat 31, `dump_req` held high during dump starts nothing extra until IDLE.
- Write during dump: write RF[20]=0xBEEF on the edge that samples idx 20 → beat shows old value; later read shows 0xBEEF.
- Reset mid-dump at beat 10 → `dump_valid`/`dump_busy` drop asynchronously, no `dump_done`, next `dump_req` restarts at idx 0.
